// File: rtl/if_id_fetch_ctrl.sv
// if_id_fetch_ctrl: instruction fetch controller feeding the IF/ID pipeline register.
// Owns the PC and keeps at most one instruction-memory request outstanding.
// Returned instructions either bypass straight into IF/ID or wait in a small FIFO.
// Stall holds IF/ID. Flush squashes all wrong-path state and redirects the PC.
// Optional build macro IF_PERF_CNT_EN adds stall and flush event counters;
// without it, both counter ports read as zero.
module if_id_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  fetch_state_t     state;
  logic [31:0]      pc;
  logic [31:0]      req_pc;

  logic [31:0]      fifo_pc    [DEPTH];
  logic [31:0]      fifo_instr [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic resp_wait;
  logic advance;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic push;
  logic room;
  logic can_issue;
  logic grant;

  assign imem_addr = pc;

  // Decide this cycle's FIFO movement, IF/ID source, and whether a new request may be issued.
  always_comb begin
    resp_wait  = (state == ST_WAIT) && imem_rvalid;
    advance    = !stall && !flush;
    fifo_empty = (count == '0);
    pop        = advance && !fifo_empty;
    bypass     = advance && fifo_empty && resp_wait;
    push       = resp_wait && !flush && !bypass;
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
    room      = (count_next < CNT_W'(DEPTH));
    can_issue = (state == ST_FETCH) || resp_wait;
    imem_req  = !rst && !flush && can_issue && room;
    grant     = imem_req && imem_gnt;
  end

  // Advance the PC and track whether a request is outstanding or squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      state  <= ST_FETCH;
    end else if (flush) begin
      pc    <= br_target;
      state <= (state == ST_FETCH || imem_rvalid) ? ST_FETCH : ST_DROP;
    end else begin
      if (grant) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      case (state)
        ST_FETCH: begin
          if (grant) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= grant ? ST_WAIT : ST_FETCH;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Maintain FIFO occupancy and pointers; a flush discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Store a returned instruction with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc[wr_ptr]    <= req_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  // Load IF/ID from the FIFO head or a bypassed response; otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (pop) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= fifo_pc[rd_ptr];
        if_id_instr <= fifo_instr[rd_ptr];
      end else if (bypass) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_instr <= imem_rdata;
      end else begin
        if_id_valid <= 1'b0;
        if_id_pc    <= '0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Count stalled cycles that are not overridden by a flush, and count flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !flush) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// tb_if_id_fetch_ctrl: scoreboard bench for if_id_fetch_ctrl.
// The memory model grants requests and answers after a delay, using address-derived data.
// Each accepted fetch pushes its expected {pc, instr} into a queue.
// A monitor pops the queue whenever IF/ID presents a newly loaded instruction.
module tb_if_id_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int          checks = 0;
  int          failures = 0;
  int          presented = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_fetch = RESET_PC;
  bit          mem_random = 1'b0;
  bit          stray_en = 1'b0;

  if_id_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (2),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .br_target     (br_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One cycle of control stimulus, returning at the following falling edge.
  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] t, input logic r);
    @(posedge clk);
    #1;
    rst       = r;
    stall     = s;
    flush     = f;
    br_target = t;
    @(negedge clk);
  endtask

  // Memory model: tracks the fetch stream, checks the request protocol, and feeds the scoreboard.
  initial begin
    bit          pend_active;
    int          pend_wait;
    logic [31:0] pend_addr;
    bit          stray_pending;
    bit          hold_prev;
    logic [31:0] hold_addr;
    pend_active   = 1'b0;
    pend_wait     = 0;
    pend_addr     = '0;
    stray_pending = 1'b0;
    hold_prev     = 1'b0;
    hold_addr     = '0;
    imem_gnt      = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        checkOutput("req_in_reset", 32'(imem_req), 32'd0);
        pend_active = 1'b0;
        sb_q.delete();
        exp_fetch = RESET_PC;
        hold_prev = 1'b0;
        if (stray_en) stray_pending = 1'b1;
      end else begin
        if (imem_rvalid) pend_active = 1'b0;
        if (flush) checkOutput("req_on_flush", 32'(imem_req), 32'd0);
        if (hold_prev && imem_req) checkOutput("addr_stable", imem_addr, hold_addr);
        hold_prev = imem_req && !imem_gnt;
        hold_addr = imem_addr;
        if (imem_req && imem_gnt) begin
          checkOutput("one_outstanding", 32'(pend_active), 32'd0);
          checkOutput("fetch_addr", imem_addr, exp_fetch);
          sb_q.push_back(exp_fetch);
          exp_fetch   = exp_fetch + 32'd4;
          pend_active = 1'b1;
          pend_addr   = imem_addr;
          pend_wait   = mem_random ? int'($urandom_range(0, 2)) : 0;
        end
        if (flush) begin
          sb_q.delete();
          exp_fetch = br_target;
        end
      end
      @(posedge clk);
      #1;
      if (stray_pending) begin
        imem_rvalid   = 1'b1;
        imem_rdata    = $urandom;
        imem_gnt      = 1'b0;
        stray_pending = 1'b0;
      end else begin
        if (pend_active && pend_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = enc(pend_addr);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom;
          if (pend_active) pend_wait--;
        end
        imem_gnt = mem_random ? ($urandom_range(0, 9) < 7) : 1'b1;
      end
    end
  end

  // Monitor: compares IF/ID against the scoreboard, the hold/bubble rules, and the perf counter model.
  initial begin
    bit          p_rst;
    bit          p_stall;
    bit          p_flush;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] e;
    logic [31:0] ps;
    logic [31:0] pf;
    logic [31:0] exp_s;
    logic [31:0] exp_f;
    int          idle;
    int          cyc;
    p_rst   = 1'b1;
    p_stall = 1'b0;
    p_flush = 1'b0;
    m_valid = 1'b0;
    m_pc    = '0;
    m_instr = NOP;
    ps      = '0;
    pf      = '0;
    idle    = 0;
    cyc     = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (p_rst || p_flush) begin
        checkOutput("bubble_valid", 32'(if_id_valid), 32'd0);
        checkOutput("bubble_pc", if_id_pc, 32'd0);
        checkOutput("bubble_instr", if_id_instr, NOP);
        m_valid = 1'b0;
        m_pc    = '0;
        m_instr = NOP;
        idle    = 0;
      end else if (p_stall) begin
        checkOutput("hold_valid", 32'(if_id_valid), 32'(m_valid));
        checkOutput("hold_pc", if_id_pc, m_pc);
        checkOutput("hold_instr", if_id_instr, m_instr);
      end else if (if_id_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_instr: got pc %h, expected no instruction", if_id_pc);
        end else begin
          e = sb_q.pop_front();
          checkOutput("if_id_pc", if_id_pc, e);
          checkOutput("if_id_instr", if_id_instr, enc(e));
          m_valid = 1'b1;
          m_pc    = e;
          m_instr = enc(e);
          presented++;
        end
        idle = 0;
      end else begin
        checkOutput("empty_pc", if_id_pc, 32'd0);
        checkOutput("empty_instr", if_id_instr, NOP);
        m_valid = 1'b0;
        m_pc    = '0;
        m_instr = NOP;
        idle++;
        if (idle > 64) begin
          checks++;
          failures++;
          $display("[TB] FAIL progress: got %0d idle cycles, expected at most 64", idle);
          idle = 0;
        end
      end
      if (p_rst) begin
        ps = '0;
        pf = '0;
      end else begin
        if (p_stall && !p_flush) ps = ps + 32'd1;
        if (p_flush) pf = pf + 32'd1;
      end
`ifdef IF_PERF_CNT_EN
      exp_s = ps;
      exp_f = pf;
`else
      exp_s = '0;
      exp_f = '0;
`endif
      if (cyc % 16 == 0) begin
        checkOutput("perf_stall_cnt", perf_stall_cnt, exp_s);
        checkOutput("perf_flush_cnt", perf_flush_cnt, exp_f);
      end
      p_rst   = rst;
      p_stall = stall;
      p_flush = flush;
    end
  end

  // Directed scenarios followed by a long randomized run.
  initial begin
    int          stall_left;
    logic        s;
    logic        f;
    logic        r;
    logic [31:0] t;
    rst        = 1'b1;
    stall      = 1'b0;
    flush      = 1'b0;
    br_target  = '0;
    stall_left = 0;

    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("rst_valid", 32'(if_id_valid), 32'd0);
    checkOutput("rst_instr", if_id_instr, NOP);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_perf_stall", perf_stall_cnt, 32'd0);
    checkOutput("rst_perf_flush", perf_flush_cnt, 32'd0);

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c1_req", 32'(imem_req), 32'd1);
    checkOutput("c1_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c2_addr", imem_addr, 32'h4);
    checkOutput("c2_valid", 32'(if_id_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c3_valid", 32'(if_id_valid), 32'd1);
    checkOutput("c3_pc", if_id_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c4_pc", if_id_pc, 32'h4);

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("c5_pc", if_id_pc, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("c6_hold_pc", if_id_pc, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("c7_req_full", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("c8_hold_pc", if_id_pc, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c9_hold_pc", if_id_pc, 32'h8);
    checkOutput("c9_addr", imem_addr, 32'h14);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c10_pc", if_id_pc, 32'hC);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c11_pc", if_id_pc, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("c12_pc", if_id_pc, 32'h14);

    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("sf_valid", 32'(if_id_valid), 32'd0);
    checkOutput("sf_instr", if_id_instr, NOP);
    checkOutput("sf_addr", imem_addr, 32'h100);
    checkOutput("sf_req", 32'(imem_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("sf_bubble2", 32'(if_id_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("sf_target_pc", if_id_pc, 32'h100);
    checkOutput("sf_target_instr", if_id_instr, enc(32'h100));

    mem_random = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if (i == 900) stray_en = 1'b1;
      if (i == 903) stray_en = 1'b0;
      r = (i == 900 || i == 901);
      if (stall_left == 0 && $urandom_range(0, 9) == 0) stall_left = int'($urandom_range(1, 5));
      s = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      f = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       t = 32'hFFFF_FFF8;
        1:       t = $urandom & 32'hFFFF_FFFC;
        default: t = 32'($urandom_range(0, 255)) << 2;
      endcase
      if (r) begin
        s = 1'b0;
        f = 1'b0;
      end
      applyStimulus(s, f, t, r);
    end
    repeat (20) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    checks++;
    if (presented < 300) begin
      failures++;
      $display("[TB] FAIL throughput: got %0d instructions, expected at least 300", presented);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the run never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
